// File: rtl/e15_imem_loader.sv
// E15 instruction-memory loader: streams a program into a 16-entry memory over valid/ready,
// zero-fills the unused tail, then serves combinational fetches once the program is complete.
module e15_imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_instr_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic              load_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                load_err_q, load_err_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                beat;

  // Memory is deliberately left out of reset so a reset does not erase a loaded program.
  logic [DATA_W-1:0]   mem [DEPTH];

  assign beat = in_valid_i && (state_q == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      IDLE, RUN: begin
        if (load_start_i) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (beat) begin
          mem_we       = 1'b1;
          mem_wdata    = in_data_i;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          // A full memory ends the load whether or not the sender flagged the last word.
          if (wr_ptr_q == LAST_IDX) begin
            state_d = RUN;
            if (!in_last_i) begin
              load_err_d = 1'b1;
            end
          end else if (in_last_i) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside RUN the fetch returns jmp +0 so the processor spins in place.
  always_comb begin
    in_ready_o    = 1'b0;
    cpu_run_o     = 1'b0;
    fetch_instr_o = '0;
    case (state_q)
      LOAD:    in_ready_o = 1'b1;
      RUN: begin
        cpu_run_o     = 1'b1;
        fetch_instr_o = mem[fetch_addr_i];
      end
      default: ;
    endcase
  end

  assign load_count_o = load_count_q;
  assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_e15_imem_loader.sv
// Directed bench for e15_imem_loader: table-driven beat streams and fetch sweeps,
// plus hand-written sequences for reset, fill latency and ignored load_start.
module tb_e15_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  fetch_addr;
  logic [11:0] fetch_instr;
  logic        cpu_run;
  logic [4:0]  load_count;
  logic        load_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic [11:0] data;
    logic        last;
    logic [4:0]  exp_count;
  } beat_t;

  beat_t       gap_tab [6];
  logic [11:0] exp_mem [16];

  e15_imem_loader #(.ADDR_W(4), .DATA_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start_i (load_start),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .fetch_addr_i (fetch_addr),
    .fetch_instr_o(fetch_instr),
    .cpu_run_o    (cpu_run),
    .load_count_o (load_count),
    .load_err_o   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input string name);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_count0"}, {27'd0, load_count}, 32'd0);
    check({name, "_err0"}, {31'd0, load_err}, 32'd0);
    check({name, "_run0"}, {31'd0, cpu_run}, 32'd0);
  endtask

  task automatic send_beat(input logic [11:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = 12'h000;
    in_last  = 1'b0;
    $display("beat data=%03h last=%0b count=%0d", data, last, load_count);
  endtask

  task automatic wait_run(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (cpu_run !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  task automatic verify_mem(input string name);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      check($sformatf("%s_addr%0d", name, a), {20'd0, fetch_instr}, {20'd0, exp_mem[a]});
    end
    fetch_addr = 4'd0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({name, "_run"}, {31'd0, cpu_run}, 32'd0);
    check({name, "_fetch"}, {20'd0, fetch_instr}, 32'd0);
    check({name, "_count"}, {27'd0, load_count}, 32'd0);
    check({name, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    gap_tab[0] = '{valid: 1'b1, data: 12'h901, last: 1'b0, exp_count: 5'd1};
    gap_tab[1] = '{valid: 1'b0, data: 12'hFFF, last: 1'b1, exp_count: 5'd1};
    gap_tab[2] = '{valid: 1'b0, data: 12'hEEE, last: 1'b1, exp_count: 5'd1};
    gap_tab[3] = '{valid: 1'b1, data: 12'hB02, last: 1'b0, exp_count: 5'd2};
    gap_tab[4] = '{valid: 1'b0, data: 12'hDDD, last: 1'b1, exp_count: 5'd2};
    gap_tab[5] = '{valid: 1'b1, data: 12'h0F0, last: 1'b1, exp_count: 5'd3};

    rst_n      = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 12'h000;
    in_last    = 1'b0;
    fetch_addr = 4'd0;

    // Test 1: asynchronous reset asserted mid-cycle
    #12;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t1_reset");
    #10;
    rst_n = 1'b1;
    tick();
    check("t1_idle_holds", {31'd0, in_ready}, 32'd0);

    // Test 2: three-word program, 13 fill cycles
    start_load("t2_start");
    send_beat(12'h901, 1'b0);
    send_beat(12'hB02, 1'b0);
    send_beat(12'h0F0, 1'b1);
    check("t2_fill_ready", {31'd0, in_ready}, 32'd0);
    check("t2_fill_run", {31'd0, cpu_run}, 32'd0);
    check("t2_fill_fetch", {20'd0, fetch_instr}, 32'd0);
    wait_run("t2_fill_cycles", 13);
    check("t2_count", {27'd0, load_count}, 32'd3);
    check("t2_err", {31'd0, load_err}, 32'd0);
    for (int a = 0; a < 16; a++) exp_mem[a] = 12'h000;
    exp_mem[0] = 12'h901;
    exp_mem[1] = 12'hB02;
    exp_mem[2] = 12'h0F0;
    verify_mem("t2_mem");

    // Test 3: same program with in_valid gaps; junk data on idle cycles must not land
    start_load("t3_start");
    for (int i = 0; i < 6; i++) begin
      in_valid = gap_tab[i].valid;
      in_data  = gap_tab[i].data;
      in_last  = gap_tab[i].last;
      tick();
      $display("vec %0d valid=%0b data=%03h last=%0b count=%0d", i, gap_tab[i].valid,
               gap_tab[i].data, gap_tab[i].last, load_count);
      check($sformatf("t3_vec%0d_count", i), {27'd0, load_count}, {27'd0, gap_tab[i].exp_count});
      if (i < 5) check($sformatf("t3_vec%0d_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    in_data  = 12'h000;
    in_last  = 1'b0;
    wait_run("t3_fill_cycles", 13);
    verify_mem("t3_mem");

    // Test 4: sixteen words with no in_last -> immediate run, sticky error
    start_load("t4_start");
    for (int i = 0; i < 16; i++) begin
      send_beat(12'hA00 + 12'(i), 1'b0);
      if (i < 15) begin
        check($sformatf("t4_beat%0d_run", i), {31'd0, cpu_run}, 32'd0);
        check($sformatf("t4_beat%0d_fetch", i), {20'd0, fetch_instr}, 32'd0);
      end
    end
    check("t4_run_next_cycle", {31'd0, cpu_run}, 32'd1);
    check("t4_ready", {31'd0, in_ready}, 32'd0);
    check("t4_count", {27'd0, load_count}, 32'd16);
    check("t4_err", {31'd0, load_err}, 32'd1);
    for (int a = 0; a < 16; a++) exp_mem[a] = 12'hA00 + 12'(a);
    verify_mem("t4_mem");

    // Test 6b: load_start from RUN clears run, count and error
    start_load("t6_restart");

    // Test 6a: load_start inside LOAD and FILL is ignored
    load_start = 1'b1;
    send_beat(12'h111, 1'b0);
    load_start = 1'b0;
    check("t6_count_after_ls_beat", {27'd0, load_count}, 32'd1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t6_count_after_ls_idle", {27'd0, load_count}, 32'd1);
    check("t6_ready_in_load", {31'd0, in_ready}, 32'd1);
    send_beat(12'h222, 1'b1);
    check("t6_count", {27'd0, load_count}, 32'd2);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t6_fill_ignores_ls", {31'd0, in_ready}, 32'd0);
    wait_run("t6_fill_cycles", 13);
    for (int a = 0; a < 16; a++) exp_mem[a] = 12'h000;
    exp_mem[0] = 12'h111;
    exp_mem[1] = 12'h222;
    verify_mem("t6_mem");

    // Test 5: reset during FILL, then a one-word program
    start_load("t5_start");
    send_beat(12'h555, 1'b1);
    tick();
    tick();
    tick();
    check("t5_in_fill", {31'd0, in_ready | cpu_run}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    #3;
    rst_n = 1'b1;
    tick();
    check("t5_idle_ready", {31'd0, in_ready}, 32'd0);
    check("t5_idle_run", {31'd0, cpu_run}, 32'd0);
    start_load("t5_reload");
    send_beat(12'h9A0, 1'b1);
    wait_run("t5_fill_cycles", 15);
    check("t5_count", {27'd0, load_count}, 32'd1);
    for (int a = 0; a < 16; a++) exp_mem[a] = 12'h000;
    exp_mem[0] = 12'h9A0;
    verify_mem("t5_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
